// File: rtl/game_fsm.sv
// game_fsm: START/PICK/GUESS/CHECK/RESULT/END sequencer for guess-who.
// Define GAME_FSM_CHECK_TIMEOUT_EN to let CHECK time out back to GUESS.
package vga_pkg;
  localparam logic [11:0] X_1_DIM = 12'd100;
  localparam logic [11:0] X_2_DIM = 12'd300;
  localparam logic [11:0] X_3_DIM = 12'd500;
  localparam logic [11:0] Y_1_DIM = 12'd50;
  localparam logic [11:0] Y_2_DIM = 12'd250;
  localparam logic [11:0] Y_3_DIM = 12'd450;
  localparam logic [11:0] A_side  = 12'd150;
  localparam logic [11:0] B_side  = 12'd150;
endpackage

module game_fsm
  import vga_pkg::*;
#(
  parameter int CHECK_TIMEOUT = 65_000_000,
  parameter int RESULT_HOLD   = 65_000_000,
  parameter int RST_PULSE     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        reset_btn,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [1:0]  resoult,
  input  logic        peer_reset,
  output logic [5:0]  state_bin,
  output logic [3:0]  your_person,
  output logic        rst_sys
);

  typedef enum logic [5:0] {
    S_START  = 6'b000001,
    S_GUESS  = 6'b000010,
    S_CHECK  = 6'b000100,
    S_RESULT = 6'b001000,
    S_END    = 6'b010000,
    S_PICK   = 6'b100000
  } state_t;

  localparam logic [31:0] CT_LAST = 32'(CHECK_TIMEOUT - 1);
  localparam logic [31:0] RH_LAST = 32'(RESULT_HOLD - 1);
  localparam logic [31:0] RP_LAST = 32'(RST_PULSE - 1);

  state_t      state_q;
  logic [3:0]  person_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_inc;
  logic [31:0] pcnt_q;
  logic        rst_sys_q;
  logic [1:0]  st_sync_q;
  logic [1:0]  rb_sync_q;
  logic        st_prev_q;
  logic        rb_prev_q;
  logic        ml_prev_q;
  logic        mr_prev_q;
  logic        start_edge;
  logic        reset_edge;
  logic        ml_edge;
  logic        mr_edge;
  logic        col_ok;
  logic        row_ok;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        hit;
  logic [3:0]  tile;

  assign start_edge = st_sync_q[1] & ~st_prev_q;
  assign reset_edge = rb_sync_q[1] & ~rb_prev_q;
  assign ml_edge    = mouse_left & ~ml_prev_q;
  assign mr_edge    = mouse_right & ~mr_prev_q;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  assign state_bin   = state_q;
  assign your_person = person_q;
  assign rst_sys     = rst_sys_q;

`ifndef GAME_FSM_CHECK_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^CT_LAST;
`endif

  // Button synchronisers plus edge history for buttons and mouse.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_sync_q <= '0;
      rb_sync_q <= '0;
      st_prev_q <= 1'b0;
      rb_prev_q <= 1'b0;
      ml_prev_q <= 1'b0;
      mr_prev_q <= 1'b0;
    end else begin
      st_sync_q <= {st_sync_q[0], start_btn};
      rb_sync_q <= {rb_sync_q[0], reset_btn};
      st_prev_q <= st_sync_q[1];
      rb_prev_q <= rb_sync_q[1];
      ml_prev_q <= mouse_left;
      mr_prev_q <= mouse_right;
    end
  end

  // Tile hit test: inclusive bounds, tile = 3*row + col + 1.
  always_comb begin
    col_ok = 1'b1;
    row_ok = 1'b1;
    col    = 4'd0;
    row    = 4'd0;
    unique case (1'b1)
      (xpos >= X_1_DIM && xpos <= X_1_DIM + A_side): col = 4'd0;
      (xpos >= X_2_DIM && xpos <= X_2_DIM + A_side): col = 4'd1;
      (xpos >= X_3_DIM && xpos <= X_3_DIM + A_side): col = 4'd2;
      default: col_ok = 1'b0;
    endcase
    unique case (1'b1)
      (ypos >= Y_1_DIM && ypos <= Y_1_DIM + B_side): row = 4'd0;
      (ypos >= Y_2_DIM && ypos <= Y_2_DIM + B_side): row = 4'd1;
      (ypos >= Y_3_DIM && ypos <= Y_3_DIM + B_side): row = 4'd2;
      default: row_ok = 1'b0;
    endcase
    hit  = col_ok & row_ok;
    tile = row * 4'd3 + col + 4'd1;
  end

  // Game state, chosen tile and the shared CHECK/RESULT counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      person_q <= 4'd0;
      cnt_q    <= '0;
    end else if (peer_reset || reset_edge) begin
      state_q  <= S_START;
      person_q <= 4'd0;
      cnt_q    <= '0;
    end else begin
      if (state_q == S_CHECK || state_q == S_RESULT)
        cnt_q <= cnt_inc;
      else
        cnt_q <= '0;
      unique case (state_q)
        S_START: begin
          if (start_edge) begin
            state_q <= S_PICK;
            cnt_q   <= '0;
          end
        end
        S_PICK: begin
          if (ml_edge && hit) begin
            person_q <= tile;
            state_q  <= S_GUESS;
            cnt_q    <= '0;
          end
        end
        S_GUESS: begin
          if (resoult != 2'b00) begin
            state_q <= S_RESULT;
            cnt_q   <= '0;
          end else if (mr_edge && hit) begin
            state_q <= S_CHECK;
            cnt_q   <= '0;
          end
        end
        S_CHECK: begin
          if (resoult != 2'b00) begin
            state_q <= S_RESULT;
            cnt_q   <= '0;
          end
`ifdef GAME_FSM_CHECK_TIMEOUT_EN
          else if (cnt_q == CT_LAST) begin
            state_q <= S_GUESS;
            cnt_q   <= '0;
          end
`endif
        end
        S_RESULT: begin
          if (cnt_q == RH_LAST) begin
            state_q <= S_END;
            cnt_q   <= '0;
          end
        end
        S_END: begin
          if (start_edge) begin
            state_q  <= S_START;
            person_q <= 4'd0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q <= S_START;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Peer reset pulse; only a local button edge starts or restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_sys_q <= 1'b0;
      pcnt_q    <= '0;
    end else if (reset_edge) begin
      rst_sys_q <= 1'b1;
      pcnt_q    <= RP_LAST;
    end else if (pcnt_q != '0) begin
      pcnt_q    <= pcnt_q - 32'd1;
    end else begin
      rst_sys_q <= 1'b0;
    end
  end

endmodule
